// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register used while decode is stalled.
module fetch_skid_buffer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // Entry register: clear dominates load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= {XLEN{1'b0}};
      pc    <= {XLEN{1'b0}};
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= in_instr;
      pc    <= in_pc;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch: drives the PC, handshakes with instruction memory and owns IF/ID.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int unsigned     TIMEOUT  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            pc_write,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            id_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            fetch_fault
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  fetch_state_t    state, state_next;
  logic [CW-1:0]   wait_cnt, wait_next;
  logic            redirect_pending, pend_next;
  logic [XLEN-1:0] pending_target, pend_tgt_next;
  logic            valid_next, fault_next;
  logic [XLEN-1:0] instr_next, ifpc_next;
  logic            skid_load, skid_clear, skid_valid;
  logic [XLEN-1:0] skid_instr, skid_pc;
  logic [XLEN-1:0] redirect_aligned, pc_plus;

  assign imem_addr        = pc;
  assign redirect_aligned = {redirect_target[XLEN-1:2], 2'b00};
  assign pc_plus          = pc + XLEN'(PC_STEP);

  fetch_skid_buffer #(.XLEN(XLEN)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clear    (skid_clear),
    .in_instr (imem_rdata),
    .in_pc    (pc),
    .valid    (skid_valid),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  // Next-state and PC/memory controls; a redirect always beats a decode stall.
  always_comb begin
    state_next    = state;
    next_pc       = pc_plus;
    pc_write      = 1'b0;
    imem_req      = 1'b0;
    wait_next     = wait_cnt;
    pend_next     = redirect_pending;
    pend_tgt_next = pending_target;
    valid_next    = if_valid;
    instr_next    = if_instr;
    ifpc_next     = if_pc;
    fault_next    = fetch_fault;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    if (rst) begin
      next_pc = RESET_PC;
    end else begin
      case (state)
        S_RESET: begin
          pc_write   = 1'b1;
          next_pc    = RESET_PC;
          state_next = S_FETCH;
        end
        S_FETCH: begin
          imem_req = 1'b1;
          if (!imem_ready) begin
            // Address must stay put until memory answers.
            pc_write  = 1'b0;
            wait_next = wait_cnt + CW'(1);
            if (redirect_valid) begin
              pend_next     = 1'b1;
              pend_tgt_next = redirect_aligned;
              valid_next    = 1'b0;
            end else if (!id_stall) begin
              valid_next = 1'b0;
            end else begin
              valid_next = if_valid;
            end
            if (wait_cnt == CW'(TIMEOUT - 1)) begin
              state_next = S_FAULT;
              fault_next = 1'b1;
            end else begin
              state_next = S_FETCH;
            end
          end else begin
            pc_write  = 1'b1;
            wait_next = {CW{1'b0}};
            if (redirect_valid || redirect_pending) begin
              next_pc    = redirect_valid ? redirect_aligned : pending_target;
              pend_next  = 1'b0;
              valid_next = 1'b0;
              instr_next = XLEN'(NOP_INSTR);
            end else if (!id_stall) begin
              valid_next = 1'b1;
              instr_next = imem_rdata;
              ifpc_next  = pc;
            end else begin
              skid_load  = 1'b1;
              state_next = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc_write   = 1'b1;
            next_pc    = redirect_aligned;
            skid_clear = 1'b1;
            valid_next = 1'b0;
            state_next = S_FETCH;
          end else if (!id_stall) begin
            skid_clear = 1'b1;
            valid_next = skid_valid;
            instr_next = skid_instr;
            ifpc_next  = skid_pc;
            state_next = S_FETCH;
          end else begin
            pc_write = 1'b0;
          end
        end
        S_FAULT: begin
          valid_next = 1'b0;
          fault_next = 1'b1;
        end
        default: begin
          state_next = S_RESET;
        end
      endcase
    end
  end

  // State, timeout counter, pending redirect and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_RESET;
      wait_cnt         <= {CW{1'b0}};
      redirect_pending <= 1'b0;
      pending_target   <= {XLEN{1'b0}};
      if_valid         <= 1'b0;
      if_instr         <= XLEN'(NOP_INSTR);
      if_pc            <= {XLEN{1'b0}};
      fetch_fault      <= 1'b0;
    end else begin
      state            <= state_next;
      wait_cnt         <= wait_next;
      redirect_pending <= pend_next;
      pending_target   <= pend_tgt_next;
      if_valid         <= valid_next;
      if_instr         <= instr_next;
      if_pc            <= ifpc_next;
      fetch_fault      <= fault_next;
    end
  end

endmodule
